// File: rtl/life_pkg.sv
// Shared types for the frame synchroniser: buffer indices, FSM state enums and
// the free-buffer picker used by triple buffering.
package life_pkg;

    localparam int BUF_IDX_W   = 2;
    localparam int MAX_BUFS    = 3;
    localparam int MAX_READERS = 4;

    typedef logic [BUF_IDX_W-1:0] buf_idx_t;
    typedef logic [15:0]          gen_t;

    typedef enum logic {
        R_START,
        R_ACTIVE
    } render_state_t;

    typedef enum logic {
        L_IDLE,
        L_RUN
    } logic_state_t;

    // Lowest buffer index in 0..2 that is neither a nor b.
    function automatic buf_idx_t free_buf(input buf_idx_t a, input buf_idx_t b);
        buf_idx_t r;
        r = 2'd2;
        if (a != 2'd0 && b != 2'd0) begin
            r = 2'd0;
        end else if (a != 2'd1 && b != 2'd1) begin
            r = 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/buf_rotator.sv
// Owns the display/source/write buffer indices; a finished generation is
// folded in first, then a frame boundary may publish it to the readers.
module buf_rotator
    import life_pkg::*;
#(
    parameter int NUM_BUFS = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     done,
    input  logic     boundary,
    output buf_idx_t disp_buf,
    output buf_idx_t src_buf,
    output buf_idx_t dst_buf,
    output logic     swap,
    output logic     buffer_free
);

    if (NUM_BUFS < 2 || NUM_BUFS > MAX_BUFS) begin : g_bad_bufs
        $error("buf_rotator: NUM_BUFS must be 2 or 3");
    end

    logic     pending;
    logic     fresh;
    buf_idx_t src_next;
    buf_idx_t dst_next;

    always_comb begin
        src_next = src_buf;
        dst_next = dst_buf;
        if (done && NUM_BUFS == 3) begin
            src_next = dst_buf;
            dst_next = free_buf(disp_buf, dst_buf);
        end
    end

    // Double buffering must hold logic off until the readers release the old frame.
    assign fresh       = (NUM_BUFS == 2) ? (pending | done) : (src_next != disp_buf);
    assign buffer_free = (NUM_BUFS == 2) ? !pending : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_buf <= 2'd0;
            src_buf  <= 2'd0;
            dst_buf  <= 2'd1;
            pending  <= 1'b0;
            swap     <= 1'b0;
        end else begin
            swap    <= 1'b0;
            src_buf <= src_next;
            dst_buf <= dst_next;
            if (NUM_BUFS == 2 && done) begin
                pending <= 1'b1;
            end
            if (boundary && fresh) begin
                swap <= 1'b1;
                if (NUM_BUFS == 2) begin
                    disp_buf <= dst_buf;
                    src_buf  <= dst_buf;
                    dst_buf  <= disp_buf;
                    pending  <= 1'b0;
                end else begin
                    disp_buf <= src_next;
                end
            end
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Coordinates one life-logic engine and NUM_READERS frame readers over a pool
// of two or three cell buffers, with run/single-step control.
module frame_sync_ctrl
    import life_pkg::*;
#(
    parameter int NUM_BUFS    = 2,
    parameter int NUM_READERS = 1,
    parameter int GEN_W       = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   run_in,
    input  logic                   step_in,
    input  logic                   logic_done_in,
    input  logic [NUM_READERS-1:0] render_done_in,
    output logic                   logic_start_out,
    output logic [NUM_READERS-1:0] render_start_out,
    output buf_idx_t               disp_buf_out,
    output buf_idx_t               src_buf_out,
    output buf_idx_t               dst_buf_out,
    output logic                   swap_out,
    output logic [GEN_W-1:0]       gen_count_out,
    output logic                   logic_busy_out,
    output logic_state_t           logic_state_out,
    output render_state_t          render_state_out
);

    if (NUM_READERS < 1 || NUM_READERS > MAX_READERS) begin : g_bad_readers
        $error("frame_sync_ctrl: NUM_READERS must be 1..4");
    end

    // All start/done/swap signals are single-cycle strobes with no backpressure:
    // a strobe is consumed in the cycle it is seen or it is lost.
    logic [NUM_READERS-1:0] done_mask;
    logic [NUM_READERS-1:0] mask_next;
    logic                   frame_boundary;
    logic                   gen_done;
    logic                   buffer_free;

    assign mask_next      = done_mask | render_done_in;
    assign frame_boundary = (render_state_out == R_ACTIVE) && (&mask_next);
    assign gen_done       = (logic_state_out == L_RUN) && logic_done_in;

    // The boundary cycle itself issues the next start so readers rescan immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            render_state_out <= R_START;
            render_start_out <= '0;
            done_mask        <= '0;
        end else begin
            render_start_out <= '0;
            case (render_state_out)
                R_START: begin
                    render_start_out <= '1;
                    done_mask        <= '0;
                    render_state_out <= R_ACTIVE;
                end
                R_ACTIVE: begin
                    if (frame_boundary) begin
                        render_start_out <= '1;
                        done_mask        <= '0;
                    end else begin
                        done_mask <= mask_next;
                    end
                end
                default: render_state_out <= R_START;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            logic_state_out <= L_IDLE;
            logic_start_out <= 1'b0;
            logic_busy_out  <= 1'b0;
            gen_count_out   <= '0;
        end else begin
            logic_start_out <= 1'b0;
            case (logic_state_out)
                L_IDLE: begin
                    if ((run_in || step_in) && buffer_free) begin
                        logic_start_out <= 1'b1;
                        logic_busy_out  <= 1'b1;
                        logic_state_out <= L_RUN;
                    end
                end
                L_RUN: begin
                    if (logic_done_in) begin
                        gen_count_out   <= gen_count_out + GEN_W'(1);
                        logic_busy_out  <= 1'b0;
                        logic_state_out <= L_IDLE;
                    end
                end
                default: logic_state_out <= L_IDLE;
            endcase
        end
    end

    buf_rotator #(
        .NUM_BUFS(NUM_BUFS)
    ) u_rotator (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .done       (gen_done),
        .boundary   (frame_boundary),
        .disp_buf   (disp_buf_out),
        .src_buf    (src_buf_out),
        .dst_buf    (dst_buf_out),
        .swap       (swap_out),
        .buffer_free(buffer_free)
    );

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: a double-buffered single-reader instance and a
// triple-buffered three-reader instance checked against a frame/generation model.
module tb_frame_sync_ctrl;
    import life_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic a_run, a_step, a_ldone;
    logic [0:0] a_rdone, a_rstart;
    logic a_lstart, a_swap, a_busy;
    buf_idx_t a_disp, a_src, a_dst;
    logic [15:0] a_gen;
    logic_state_t a_lst;
    render_state_t a_rst;

    logic b_run, b_step, b_ldone;
    logic [2:0] b_rdone, b_rstart;
    logic b_lstart, b_swap, b_busy;
    buf_idx_t b_disp, b_src, b_dst;
    logic [15:0] b_gen;
    logic_state_t b_lst;
    render_state_t b_rst;

    frame_sync_ctrl #(.NUM_BUFS(2), .NUM_READERS(1), .GEN_W(16)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .run_in(a_run), .step_in(a_step),
        .logic_done_in(a_ldone), .render_done_in(a_rdone),
        .logic_start_out(a_lstart), .render_start_out(a_rstart),
        .disp_buf_out(a_disp), .src_buf_out(a_src), .dst_buf_out(a_dst),
        .swap_out(a_swap), .gen_count_out(a_gen), .logic_busy_out(a_busy),
        .logic_state_out(a_lst), .render_state_out(a_rst)
    );

    frame_sync_ctrl #(.NUM_BUFS(3), .NUM_READERS(3), .GEN_W(16)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .run_in(b_run), .step_in(b_step),
        .logic_done_in(b_ldone), .render_done_in(b_rdone),
        .logic_start_out(b_lstart), .render_start_out(b_rstart),
        .disp_buf_out(b_disp), .src_buf_out(b_src), .dst_buf_out(b_dst),
        .swap_out(b_swap), .gen_count_out(b_gen), .logic_busy_out(b_busy),
        .logic_state_out(b_lst), .render_state_out(b_rst)
    );

    int checks = 0;
    int errors = 0;

    // Model: which readers have finished the frame, whether a generation is in
    // flight, and which buffer is shown / newest complete / being written.
    typedef struct {
        bit       opened;
        bit [3:0] seen;
        bit       busy;
        bit       fresh;
        int       disp;
        int       src;
        int       wr;
        int       gen;
        bit       lstart;
        bit       rstart;
        bit       swap;
    } model_t;

    typedef struct {
        int run, step, ldone, rdone;
        int lstart, rstart, swap, busy;
        int disp, src, dst, gen;
    } vec_t;

    model_t ma, mb;
    vec_t   vt[17];

    function automatic model_t model_reset();
        model_t m;
        m.opened = 0; m.seen = '0; m.busy = 0; m.fresh = 0;
        m.disp = 0; m.src = 0; m.wr = 1; m.gen = 0;
        m.lstart = 0; m.rstart = 0; m.swap = 0;
        return m;
    endfunction

    function automatic model_t model_next(input model_t m, input bit run, input bit step,
                                          input bit ldone, input logic [3:0] rdone,
                                          input int nb, input int nr);
        model_t n;
        int     count;
        int     old;
        bit     boundary;
        bit     start;
        bit     done;
        n = m;
        n.lstart = 0; n.rstart = 0; n.swap = 0;
        boundary = 0;
        if (!m.opened) begin
            n.opened = 1;
            n.rstart = 1;
        end else begin
            count = 0;
            for (int i = 0; i < nr; i++) begin
                if (rdone[i]) n.seen[i] = 1;
                if (n.seen[i]) count++;
            end
            if (count == nr) begin
                boundary = 1;
                n.rstart = 1;
                n.seen = '0;
            end
        end
        start = !m.busy && (run || step) && (nb == 3 || !m.fresh);
        done  = m.busy && ldone;
        if (start) begin
            n.busy = 1;
            n.lstart = 1;
        end
        if (done) begin
            n.busy = 0;
            n.gen = (m.gen + 1) % 65536;
            if (nb == 2) begin
                n.fresh = 1;
            end else begin
                n.src = m.wr;
                for (int b = 2; b >= 0; b--) if (b != m.disp && b != m.wr) n.wr = b;
            end
        end
        if (boundary) begin
            if (nb == 2 && n.fresh) begin
                old = n.disp;
                n.disp = n.wr; n.src = n.wr; n.wr = old;
                n.fresh = 0; n.swap = 1;
            end else if (nb == 3 && n.src != n.disp) begin
                n.disp = n.src;
                n.swap = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] pack_o(input logic ls, input logic [3:0] rs, input logic sw,
                                           input logic bz, input buf_idx_t d, input buf_idx_t s,
                                           input buf_idx_t w, input logic [15:0] g);
        return {3'b0, ls, rs, sw, bz, d, s, w, g};
    endfunction

    function automatic logic [31:0] pack_m(input model_t m, input int nr);
        logic [3:0] rs;
        rs = m.rstart ? 4'((1 << nr) - 1) : 4'd0;
        return pack_o(m.lstart, rs, m.swap, m.busy, 2'(m.disp), 2'(m.src), 2'(m.wr), 16'(m.gen));
    endfunction

    function automatic logic [31:0] pack_a();
        return pack_o(a_lstart, {3'b0, a_rstart}, a_swap, a_busy, a_disp, a_src, a_dst, a_gen);
    endfunction

    function automatic logic [31:0] pack_b();
        return pack_o(b_lstart, {1'b0, b_rstart}, b_swap, b_busy, b_disp, b_src, b_dst, b_gen);
    endfunction

    function automatic vec_t mk(input int run, input int step, input int ldone, input int rdone,
                                input int lstart, input int rstart, input int swap, input int busy,
                                input int disp, input int src, input int dst, input int gen);
        vec_t v;
        v.run = run; v.step = step; v.ldone = ldone; v.rdone = rdone;
        v.lstart = lstart; v.rstart = rstart; v.swap = swap; v.busy = busy;
        v.disp = disp; v.src = src; v.dst = dst; v.gen = gen;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a_run = 0; a_step = 0; a_ldone = 0; a_rdone = '0;
        b_run = 0; b_step = 0; b_ldone = 0; b_rdone = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", pack_a(), pack_o(0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));
        check("reset_b", pack_b(), pack_o(0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        ma = model_reset();
        mb = model_reset();
    endtask

    initial begin
        int p_ld;
        int p_rd;

        // run, step, ldone, rdone | lstart, rstart, swap, busy, disp, src, dst, gen
        vt[0]  = mk(0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1, 0);
        vt[1]  = mk(0, 1, 0, 0,  1, 0, 0, 1,  0, 0, 1, 0);
        vt[2]  = mk(0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 1, 0);
        vt[3]  = mk(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 1, 1);
        vt[4]  = mk(0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1);
        vt[5]  = mk(0, 0, 0, 1,  0, 1, 1, 0,  1, 1, 0, 1);
        vt[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 1);
        vt[7]  = mk(0, 0, 0, 1,  0, 1, 0, 0,  1, 1, 0, 1);
        vt[8]  = mk(0, 0, 1, 0,  0, 0, 0, 0,  1, 1, 0, 1);
        vt[9]  = mk(1, 0, 0, 0,  1, 0, 0, 1,  1, 1, 0, 1);
        vt[10] = mk(1, 0, 0, 1,  0, 1, 0, 1,  1, 1, 0, 1);
        vt[11] = mk(1, 0, 1, 0,  0, 0, 0, 0,  1, 1, 0, 2);
        vt[12] = mk(0, 0, 0, 1,  0, 1, 1, 0,  0, 0, 1, 2);
        vt[13] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 2);
        vt[14] = mk(1, 0, 0, 0,  1, 0, 0, 1,  0, 0, 1, 2);
        vt[15] = mk(0, 0, 1, 1,  0, 1, 1, 0,  1, 1, 0, 3);
        vt[16] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 3);

        // Double-buffer sequence: step, dropped steps, ignored done, swap timing.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            a_run = (vt[i].run != 0);
            a_step = (vt[i].step != 0);
            a_ldone = (vt[i].ldone != 0);
            a_rdone[0] = (vt[i].rdone != 0);
            @(posedge clk);
            #1;
            check($sformatf("vec_%0d", i), pack_a(),
                  pack_o(vt[i].lstart != 0, {3'b0, vt[i].rstart != 0}, vt[i].swap != 0,
                         vt[i].busy != 0, 2'(vt[i].disp), 2'(vt[i].src), 2'(vt[i].dst),
                         16'(vt[i].gen)));
        end

        // Three readers finishing at cycles 10, 25, 40 with a repeat from reader 0.
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("readers_start_c%0d", k), 32'(b_rstart),
                  (k == 1 || k == 41) ? 32'h7 : 32'h0);
            case (k)
                10: b_rdone = 3'b001;
                25: b_rdone = 3'b100;
                30: b_rdone = 3'b001;
                40: b_rdone = 3'b010;
                default: b_rdone = 3'b000;
            endcase
        end

        // Asynchronous reset with a generation pending / in flight.
        do_reset();
        a_step = 1; b_step = 1;
        @(posedge clk);
        #1;
        check("rst_seq_start_a", 32'(a_lstart), 32'd1);
        check("rst_seq_start_b", 32'(b_lstart), 32'd1);
        a_step = 0; b_step = 0; a_ldone = 1;
        @(posedge clk);
        #1;
        a_ldone = 0;
        check("rst_seq_gen_a", 32'(a_gen), 32'd1);
        check("rst_seq_busy_b", 32'(b_busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", pack_a(), pack_o(0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));
        check("async_reset_b", pack_b(), pack_o(0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_ldone = 1; b_ldone = 1;
        @(posedge clk);
        #1;
        a_ldone = 0; b_ldone = 0;
        check("late_done_a", pack_a(), pack_o(0, 4'd1, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));
        check("late_done_b", pack_b(), pack_o(0, 4'd7, 0, 0, 2'd0, 2'd0, 2'd1, 16'd0));

        // Random run/step/done traffic on both instances against the model.
        do_reset();
        p_ld = 6;
        p_rd = 15;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                p_ld = 30;
                p_rd = 4;
            end
            if ($urandom_range(0, 49) == 0) a_run = ~a_run;
            if ($urandom_range(0, 49) == 0) b_run = ~b_run;
            a_step = ($urandom_range(0, 9) == 0);
            b_step = ($urandom_range(0, 9) == 0);
            a_ldone = ($urandom_range(0, p_ld - 1) == 0);
            b_ldone = ($urandom_range(0, p_ld - 1) == 0);
            a_rdone[0] = ($urandom_range(0, p_rd - 1) == 0);
            for (int r = 0; r < 3; r++) b_rdone[r] = ($urandom_range(0, p_rd - 1) == 0);
            ma = model_next(ma, a_run, a_step, a_ldone, {3'b0, a_rdone}, 2, 1);
            mb = model_next(mb, b_run, b_step, b_ldone, {1'b0, b_rdone}, 3, 3);
            @(posedge clk);
            #1;
            check($sformatf("rand_a_c%0d", cyc), pack_a(), pack_m(ma, 1));
            check($sformatf("rand_b_c%0d", cyc), pack_b(), pack_m(mb, 3));
            check("inv_a_src_eq_disp", 32'(a_src == a_disp), 32'd1);
            check("inv_a_dst_ne_disp", 32'(a_dst != a_disp), 32'd1);
            check("inv_b_dst_ne_disp", 32'(b_dst != b_disp), 32'd1);
            check("inv_b_dst_ne_src", 32'(b_dst != b_src), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
